// File: rtl/cpu_op_sequencer.sv
// Command-level sequencer for the cpu datapath: accepts one operation, drives the
// datapath controls for 1+LAT cycles, captures the result and returns it as a response.
module cpu_op_sequencer #(
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_a,
  input  logic [4:0]       cmd_b,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [4:0]       addressA,
  output logic [4:0]       addressB,
  output logic [31:0]      dataIn,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       opsel,
  output logic [2:0]       outsel,
  output logic             oen,
  input  logic [31:0]      outPut,
  input  logic             over,
  output logic             ovf_flag,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the sender holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] OP_STORE = 3'b000;
  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_CMP   = 3'b100;

  localparam logic [3:0] WAIT_LAST = 4'(LAT - 1);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         a_q, a_d;
  logic [4:0]         b_q, b_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         wait_q, wait_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_err_q, rsp_err_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic cmd_fire;
  logic cmd_legal;
  logic capture;
  logic rsp_fire;
  logic cap_ovf;

  assign cmd_fire  = cmd_valid && (state_q == S_IDLE);
  assign cmd_legal = (cmd_op <= OP_CMP);
  assign capture   = (state_q == S_WAIT) && (wait_q == WAIT_LAST);
  assign rsp_fire  = (state_q == S_RESP) && rsp_ready;
  // Only arithmetic ops report overflow; the datapath's flag is meaningless otherwise.
  assign cap_ovf   = ((op_q == OP_ADD) || (op_q == OP_SUB)) && over;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = cmd_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (capture) state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, wait counter, response capture and flags
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    ovf_flag_d = ovf_flag_q;
    op_count_d = op_count_q;

    if (cmd_fire) begin
      op_d   = cmd_op;
      a_d    = cmd_a;
      b_d    = cmd_b;
      data_d = cmd_data;
      if (!cmd_legal) begin
        rsp_data_d = 32'd0;
        rsp_ovf_d  = 1'b0;
        rsp_err_d  = 1'b1;
      end
    end

    if (state_q == S_ISSUE) begin
      wait_d = 4'd0;
    end else if (state_q == S_WAIT) begin
      wait_d = wait_q + 4'd1;
    end

    if (capture) begin
      rsp_data_d = outPut;
      rsp_ovf_d  = cap_ovf;
      rsp_err_d  = 1'b0;
    end

    // Setting wins over a coincident clear so no overflow event is ever lost.
    if (capture && cap_ovf) begin
      ovf_flag_d = 1'b1;
    end else if (clr_flags) begin
      ovf_flag_d = 1'b0;
    end

    if (rsp_fire) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 3'd0;
      a_q        <= 5'd0;
      b_q        <= 5'd0;
      data_q     <= 32'd0;
      wait_q     <= 4'd0;
      rsp_data_q <= 32'd0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      ovf_flag_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_q     <= data_d;
      wait_q     <= wait_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
      ovf_flag_q <= ovf_flag_d;
      op_count_q <= op_count_d;
    end
  end

  // Output logic: datapath controls are live only in ISSUE/WAIT
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    addressA  = 5'd0;
    addressB  = 5'd0;
    dataIn    = 32'd0;
    asel      = 1'b0;
    bsel      = 1'b0;
    opsel     = 2'b00;
    outsel    = 3'b000;
    oen       = 1'b0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      oen = 1'b1;
      case (op_q)
        OP_STORE: begin
          addressB = b_q;
          dataIn   = data_q;
          opsel    = 2'b01;
        end
        OP_READ: begin
          addressA = a_q;
          addressB = a_q;
          asel     = 1'b1;
          opsel    = 2'b01;
        end
        OP_ADD: begin
          addressA = a_q;
          addressB = b_q;
          asel     = 1'b1;
          bsel     = 1'b1;
          outsel   = 3'b001;
        end
        OP_SUB: begin
          addressA = a_q;
          addressB = b_q;
          asel     = 1'b1;
          bsel     = 1'b1;
          opsel    = 2'b01;
          outsel   = 3'b001;
        end
        OP_CMP: begin
          addressA = a_q;
          addressB = b_q;
          asel     = 1'b1;
          bsel     = 1'b1;
          opsel    = 2'b01;
          outsel   = 3'b100;
        end
        default: oen = 1'b0;
      endcase
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign ovf_flag  = ovf_flag_q;
  assign op_count  = op_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Bench for cpu_op_sequencer: a behavioural register-file/ALU stub plays the datapath,
// and a reference model predicts every response, latency and flag.
module tb_cpu_op_sequencer;

  localparam int LAT   = 3;
  localparam int CNT_W = 16;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [4:0]       cmd_a, cmd_b;
  logic [31:0]      cmd_data;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_ovf, rsp_err;
  logic [4:0]       addressA, addressB;
  logic [31:0]      dataIn;
  logic             asel, bsel;
  logic [1:0]       opsel;
  logic [2:0]       outsel;
  logic             oen;
  logic [31:0]      outPut;
  logic             over;
  logic             ovf_flag, clr_flags;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0]      exp_q[$];
  logic [31:0]      m_regs [32];
  logic [CNT_W-1:0] exp_count;
  bit               exp_flag;

  cpu_op_sequencer #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .addressA(addressA), .addressB(addressB), .dataIn(dataIn),
    .asel(asel), .bsel(bsel), .opsel(opsel), .outsel(outsel), .oen(oen),
    .outPut(outPut), .over(over),
    .ovf_flag(ovf_flag), .clr_flags(clr_flags),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // datapath stub: result becomes valid only once controls have been held LAT edges
  logic [31:0] dp_regs [32];
  int          dp_held = 0;
  logic [31:0] dp_a, dp_b, dp_alu, dp_res;
  logic        dp_ov;

  initial for (int i = 0; i < 32; i++) begin
    dp_regs[i] = 32'd0;
    m_regs[i]  = 32'd0;
  end

  always @(posedge clk) begin
    if (oen) begin
      dp_held <= dp_held + 1;
      if (!asel && !bsel) dp_regs[addressB] <= dataIn;
    end else begin
      dp_held <= 0;
    end
  end

  always_comb begin
    dp_a = dp_regs[addressA];
    dp_b = dp_regs[addressB];
    if (opsel == 2'b00) begin
      dp_alu = dp_a + dp_b;
      dp_ov  = (dp_a[31] == dp_b[31]) && (dp_alu[31] != dp_a[31]);
    end else begin
      dp_alu = dp_a - dp_b;
      dp_ov  = (dp_a[31] != dp_b[31]) && (dp_alu[31] != dp_a[31]);
    end
    if (!asel && !bsel) begin
      dp_res = dataIn;
      dp_ov  = 1'b1;
    end else if (asel && !bsel) begin
      dp_res = dp_a;
      dp_ov  = 1'b1;
    end else if (outsel == 3'b001) begin
      dp_res = dp_alu;
    end else if (outsel == 3'b100) begin
      dp_res = {31'd0, $signed(dp_a) < $signed(dp_b)};
    end else begin
      dp_res = 32'hBAD0_0000;
    end
    outPut = (dp_held >= LAT) ? dp_res : 32'hDEAD_BEEF;
    over   = (dp_held >= LAT) ? dp_ov : 1'b1;
  end

  // reference model: architectural effect of one command
  task automatic ref_exec(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] d, output logic [31:0] r, output bit ov,
                          output bit er);
    longint sa, sb, s;
    sa = longint'($signed(m_regs[a]));
    sb = longint'($signed(m_regs[b]));
    r = 32'd0; ov = 1'b0; er = 1'b0;
    case (op)
      3'd0: begin m_regs[b] = d; r = d; end
      3'd1: r = m_regs[a];
      3'd2: begin s = sa + sb; r = s[31:0]; ov = (s > MAX_S) || (s < MIN_S); end
      3'd3: begin s = sa - sb; r = s[31:0]; ov = (s > MAX_S) || (s < MIN_S); end
      3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      default: er = 1'b1;
    endcase
  endtask

  // driver: one full command/response transaction with inline checks
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] d, input int hold, input bit clr_cap);
    logic [31:0] r, exp_data;
    bit ov, er, seen;
    int n, oens, exp_lat, exp_oen;
    ref_exec(op, a, b, d, r, ov, er);
    exp_q.push_back(r);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready_idle: got %0b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0; oens = 0; seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      oens += int'(oen);
      if (rsp_valid === 1'b1) seen = 1'b1;
      else if (clr_cap && n == 1 + LAT) clr_flags = 1'b1;
    end
    clr_flags = 1'b0;
    exp_lat = er ? 1 : 2 + LAT;
    exp_oen = er ? 0 : 1 + LAT;
    exp_data = exp_q.pop_front();
    total++;
    if (!seen) begin
      bad++; $display("FAIL rsp_timeout: op=%0d no rsp_valid within 64 cycles", op);
      return;
    end
    if (n != exp_lat) begin
      bad++; $display("FAIL rsp_latency: op=%0d got %0d want %0d", op, n, exp_lat);
    end
    total++;
    if (oens != exp_oen) begin
      bad++; $display("FAIL oen_cycles: op=%0d got %0d want %0d", op, oens, exp_oen);
    end
    total++;
    if (rsp_data !== exp_data) begin
      bad++; $display("FAIL rsp_data: op=%0d got %h want %h", op, rsp_data, exp_data);
    end
    total++;
    if (rsp_ovf !== ov || rsp_err !== er) begin
      bad++; $display("FAIL rsp_flags: op=%0d got ovf=%0b err=%0b want ovf=%0b err=%0b",
                      op, rsp_ovf, rsp_err, ov, er);
    end
    if (ov) exp_flag = 1'b1;
    else if (clr_cap) exp_flag = 1'b0;
    total++;
    if (ovf_flag !== exp_flag) begin
      bad++; $display("FAIL ovf_flag: got %0b want %0b", ovf_flag, exp_flag);
    end
    // a competing command during backpressure must not be taken
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 5'd3; cmd_b = 5'd7;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL rsp_hold: valid=%0b data=%h ready=%0b want 1 %h 0",
                        rsp_valid, rsp_data, cmd_ready, exp_data);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    total++;
    if (dbg_state !== 2'd0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== exp_count) begin
      bad++; $display("FAIL after_handshake: state=%0d ready=%0b valid=%0b count=%0d want 0 1 0 %0d",
                      dbg_state, cmd_ready, rsp_valid, op_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 5'd0; cmd_b = 5'd0;
    cmd_data = 32'd0; rsp_ready = 1'b0; clr_flags = 1'b0;
    exp_count = '0; exp_flag = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_ovf !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_data !== 32'd0 || ovf_flag !== 1'b0 || op_count !== '0) begin
      bad++; $display("FAIL reset_status: ready=%0b valid=%0b ovf=%0b err=%0b data=%h flag=%0b cnt=%0d",
                      cmd_ready, rsp_valid, rsp_ovf, rsp_err, rsp_data, ovf_flag, op_count);
    end
    total++;
    if (oen !== 1'b0 || addressA !== 5'd0 || addressB !== 5'd0 || dataIn !== 32'd0 ||
        asel !== 1'b0 || bsel !== 1'b0 || opsel !== 2'd0 || outsel !== 3'd0) begin
      bad++; $display("FAIL reset_datapath: oen=%0b aA=%0d aB=%0d din=%h want all 0",
                      oen, addressA, addressB, dataIn);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_add();
    do_cmd(3'd0, 5'd0, 5'd0, 32'd5, 0, 1'b0);
    do_cmd(3'd0, 5'd0, 5'd2, 32'h5555_5555, 0, 1'b0);
    do_cmd(3'd2, 5'd2, 5'd0, 32'd0, 0, 1'b0);
    total++;
    if (op_count !== 16'd3) begin
      bad++; $display("FAIL op_count_three: got %0d want 3", op_count);
    end
  endtask

  task automatic test_sub_read();
    do_cmd(3'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 0, 1'b0);
    do_cmd(3'd0, 5'd0, 5'd4, 32'd1, 0, 1'b0);
    do_cmd(3'd3, 5'd5, 5'd4, 32'd0, 1, 1'b0);
    do_cmd(3'd1, 5'd5, 5'd0, 32'd0, 0, 1'b0);
    do_cmd(3'd4, 5'd5, 5'd4, 32'd0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    do_cmd(3'd0, 5'd0, 5'd1, 32'h7FFF_FFFF, 0, 1'b0);
    do_cmd(3'd0, 5'd0, 5'd4, 32'd1, 0, 1'b0);
    do_cmd(3'd2, 5'd1, 5'd4, 32'd0, 0, 1'b0);
    do_cmd(3'd2, 5'd1, 5'd4, 32'd0, 0, 1'b1);
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    exp_flag = 1'b0;
    total++;
    if (ovf_flag !== 1'b0) begin
      bad++; $display("FAIL lone_clear: got %0b want 0", ovf_flag);
    end
    // CMP across the overflow boundary must not report overflow
    do_cmd(3'd0, 5'd0, 5'd6, 32'h8000_0000, 0, 1'b0);
    do_cmd(3'd4, 5'd1, 5'd6, 32'd0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_cmd(3'd3, 5'd1, 5'd6, 32'd0, 5, 1'b0);
    do_cmd(3'd1, 5'd2, 5'd0, 32'd0, 5, 1'b0);
  endtask

  task automatic test_illegal();
    do_cmd(3'd7, 5'd1, 5'd2, 32'h1234_5678, 0, 1'b0);
    do_cmd(3'd5, 5'd3, 5'd4, 32'h0, 2, 1'b0);
    do_cmd(3'd6, 5'd9, 5'd9, 32'hFFFF_FFFF, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_cmd(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 5'd1; cmd_b = 5'd4; cmd_data = 32'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (oen !== 1'b1 || dbg_state !== 2'd2) begin
      bad++; $display("FAIL midflight_wait: oen=%0b state=%0d want 1 2", oen, dbg_state);
    end
    rst = 1'b1;
    #1;
    exp_count = '0; exp_flag = 1'b0;
    total++;
    if (oen !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== '0 ||
        ovf_flag !== 1'b0) begin
      bad++; $display("FAIL midflight_reset: oen=%0b valid=%0b ready=%0b cnt=%0d flag=%0b want 0 0 1 0 0",
                      oen, rsp_valid, cmd_ready, op_count, ovf_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || oen !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL midflight_no_rsp: got activity after reset want none");
    end
    do_cmd(3'd1, 5'd1, 5'd0, 32'd0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store_add();
    test_sub_read();
    test_overflow();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
